// File: rtl/wb_interconnect_n.sv
// 1-master / N-slave Wishbone classic interconnect with a registered address decode.
// Unmapped addresses and stalled slaves return a bus error and are logged in sticky status.
module wb_interconnect_n #(
    parameter int WISHBONE_ADDR_WIDTH = 32,
    parameter int WISHBONE_BUS_WIDTH  = 32,
    parameter int NUM_SLAVES          = 2,
    parameter logic [NUM_SLAVES*WISHBONE_ADDR_WIDTH-1:0] SLAVE_BASE = {32'h0100_0000, 32'h0010_0000},
    parameter logic [NUM_SLAVES*WISHBONE_ADDR_WIDTH-1:0] SLAVE_MASK = {32'hFFFF_0000, 32'hFFFF_0000},
    parameter int TIMEOUT_CYCLES      = 255
) (
    input  logic                                     CLK_I,
    input  logic                                     RST_I,
    input  logic                                     WBM_CYC_O,
    input  logic                                     WBM_STB_O,
    input  logic                                     WBM_WE_O,
    input  logic [WISHBONE_ADDR_WIDTH-1:0]           WBM_ADR_O,
    input  logic [WISHBONE_BUS_WIDTH-1:0]            WBM_DAT_O,
    input  logic [WISHBONE_BUS_WIDTH/8-1:0]          WBM_SEL_O,
    output logic [WISHBONE_BUS_WIDTH-1:0]            WBM_DAT_I,
    output logic                                     WBM_ACK_I,
    output logic                                     WBM_ERR_I,
    output logic [WISHBONE_ADDR_WIDTH-1:0]           WBS_ADR_I,
    output logic                                     WBS_WE_I,
    output logic [WISHBONE_BUS_WIDTH-1:0]            WBS_DAT_I,
    output logic [WISHBONE_BUS_WIDTH/8-1:0]          WBS_SEL_I,
    output logic [NUM_SLAVES-1:0]                    WBS_CYC_I,
    output logic [NUM_SLAVES-1:0]                    WBS_STB_I,
    input  logic [NUM_SLAVES*WISHBONE_BUS_WIDTH-1:0] WBS_DAT_O,
    input  logic [NUM_SLAVES-1:0]                    WBS_ACK_O,
    input  logic [NUM_SLAVES-1:0]                    WBS_ERR_O,
    output logic                                     ERR_VALID_O,
    output logic [1:0]                               ERR_CODE_O,
    output logic [WISHBONE_ADDR_WIDTH-1:0]           ERR_ADR_O,
    input  logic                                     ERR_CLR_I
);
    localparam int AW    = WISHBONE_ADDR_WIDTH;
    localparam int BW    = WISHBONE_BUS_WIDTH;
    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, BUSY, ERROR} state_t;

    state_t            state;
    logic [IDX_W-1:0]  sel_idx;
    logic [CNT_W-1:0]  cnt;
    logic [AW-1:0]     adr_q;

    logic              req;
    logic              hit;
    logic [IDX_W-1:0]  hit_idx;
    logic              timeout;
    logic              sel_ack;
    logic              sel_err;
    logic [BW-1:0]     sel_dat;
    logic              err_capture;
    logic [1:0]        err_cause;
    logic [AW-1:0]     err_adr;

    assign req     = WBM_CYC_O & WBM_STB_O;
    assign timeout = (state == BUSY) && (cnt == TO_VAL);

    assign WBS_ADR_I = WBM_ADR_O;
    assign WBS_WE_I  = WBM_WE_O;
    assign WBS_DAT_I = WBM_DAT_O;
    assign WBS_SEL_I = WBM_SEL_O;

    // Descending scan so the lowest matching index is the last one written.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((WBM_ADR_O & SLAVE_MASK[i*AW +: AW]) == SLAVE_BASE[i*AW +: AW]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        sel_ack = 1'b0;
        sel_err = 1'b0;
        sel_dat = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_idx == IDX_W'(i)) begin
                sel_ack = WBS_ACK_O[i];
                sel_err = WBS_ERR_O[i];
                sel_dat = WBS_DAT_O[i*BW +: BW];
            end
        end
    end

    // Routing is only open in BUSY; the watchdog cycle closes it before anything is forwarded.
    always_comb begin
        WBS_CYC_I = '0;
        WBS_STB_I = '0;
        WBM_DAT_I = '0;
        WBM_ACK_I = 1'b0;
        WBM_ERR_I = 1'b0;
        if (state == BUSY && !timeout) begin
            for (int i = 0; i < NUM_SLAVES; i++) begin
                if (sel_idx == IDX_W'(i)) begin
                    WBS_CYC_I[i] = WBM_CYC_O;
                    WBS_STB_I[i] = WBM_STB_O;
                end
            end
            if (WBM_CYC_O) begin
                WBM_DAT_I = sel_dat;
                WBM_ACK_I = sel_ack;
                WBM_ERR_I = sel_err;
            end
        end else if (state == ERROR) begin
            WBM_ERR_I = 1'b1;
        end
    end

    assign err_capture = ((state == IDLE) && req && !hit) || timeout;
    assign err_cause   = timeout ? 2'b10 : 2'b01;
    assign err_adr     = timeout ? adr_q : WBM_ADR_O;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state       <= IDLE;
            sel_idx     <= '0;
            cnt         <= '0;
            ERR_VALID_O <= 1'b0;
            ERR_CODE_O  <= 2'b00;
            ERR_ADR_O   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (req) begin
                        if (hit) begin
                            sel_idx <= hit_idx;
                            state   <= BUSY;
                        end else begin
                            state   <= ERROR;
                        end
                    end
                end
                BUSY: begin
                    if (timeout) begin
                        state <= ERROR;
                        cnt   <= '0;
                    end else if (!WBM_CYC_O || sel_ack || sel_err) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt   <= cnt + CNT_W'(1);
                    end
                end
                ERROR:   state <= IDLE;
                default: state <= IDLE;
            endcase

            // A capture in the same cycle as a clear takes precedence.
            if (err_capture && (!ERR_VALID_O || ERR_CLR_I)) begin
                ERR_VALID_O <= 1'b1;
                ERR_CODE_O  <= err_cause;
                ERR_ADR_O   <= err_adr;
            end else if (ERR_CLR_I) begin
                ERR_VALID_O <= 1'b0;
                ERR_CODE_O  <= 2'b00;
                ERR_ADR_O   <= '0;
            end
        end
    end

    // Transaction address held for timeout reporting; pure data, no reset needed.
    always_ff @(posedge CLK_I) begin
        if (state == IDLE && req) begin
            adr_q <= WBM_ADR_O;
        end
    end
endmodule

// File: tb/tb_wb_interconnect_n.sv
// Directed bench for wb_interconnect_n: stimulus pushes expected master terminations,
// a negedge monitor pops and compares them; routing and status are checked inline.
module tb_wb_interconnect_n;
    logic        clk = 1'b0;
    logic        rst;
    logic        m_cyc, m_stb, m_we;
    logic [31:0] m_adr, m_dat;
    logic [3:0]  m_sel;
    logic [31:0] m_dat_i;
    logic        m_ack, m_err;
    logic [31:0] s_adr;
    logic        s_we;
    logic [31:0] s_dat_i;
    logic [3:0]  s_sel;
    logic [1:0]  s_cyc, s_stb;
    logic [63:0] s_dat;
    logic [1:0]  s_ack, s_err;
    logic        err_valid;
    logic [1:0]  err_code;
    logic [31:0] err_adr;
    logic        err_clr;

    always #5 clk = ~clk;

    wb_interconnect_n #(
        .WISHBONE_ADDR_WIDTH(32),
        .WISHBONE_BUS_WIDTH (32),
        .NUM_SLAVES         (2),
        .SLAVE_BASE         ({32'h0100_0000, 32'h0010_0000}),
        .SLAVE_MASK         ({32'hFFFF_0000, 32'hFFFF_0000}),
        .TIMEOUT_CYCLES     (4)
    ) dut (
        .CLK_I      (clk),
        .RST_I      (rst),
        .WBM_CYC_O  (m_cyc),
        .WBM_STB_O  (m_stb),
        .WBM_WE_O   (m_we),
        .WBM_ADR_O  (m_adr),
        .WBM_DAT_O  (m_dat),
        .WBM_SEL_O  (m_sel),
        .WBM_DAT_I  (m_dat_i),
        .WBM_ACK_I  (m_ack),
        .WBM_ERR_I  (m_err),
        .WBS_ADR_I  (s_adr),
        .WBS_WE_I   (s_we),
        .WBS_DAT_I  (s_dat_i),
        .WBS_SEL_I  (s_sel),
        .WBS_CYC_I  (s_cyc),
        .WBS_STB_I  (s_stb),
        .WBS_DAT_O  (s_dat),
        .WBS_ACK_O  (s_ack),
        .WBS_ERR_O  (s_err),
        .ERR_VALID_O(err_valid),
        .ERR_CODE_O (err_code),
        .ERR_ADR_O  (err_adr),
        .ERR_CLR_I  (err_clr)
    );

    typedef struct packed {
        logic        is_err;
        logic [31:0] dat;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic drive_req(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel);
        m_cyc = 1'b1;
        m_stb = 1'b1;
        m_we  = we;
        m_adr = adr;
        m_dat = dat;
        m_sel = sel;
    endtask

    task automatic drop_req();
        m_cyc = 1'b0;
        m_stb = 1'b0;
        m_we  = 1'b0;
        s_ack = 2'b00;
        s_err = 2'b00;
    endtask

    // Monitor: every termination seen by the master must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        if (m_ack || m_err) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_term", 64'({m_ack, m_err}), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("term_kind", 64'({m_ack, m_err}), e.is_err ? 64'd1 : 64'd2);
                chk("term_data", 64'(m_dat_i), 64'(e.dat));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1; err_clr = 1'b0;
        m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
        m_adr = '0; m_dat = '0; m_sel = '0;
        s_dat = '0; s_ack = '0; s_err = '0;

        // Reset state
        smp(); smp();
        chk("rst_cyc", 64'(s_cyc), 64'd0);
        chk("rst_stb", 64'(s_stb), 64'd0);
        chk("rst_term", 64'({m_ack, m_err}), 64'd0);
        chk("rst_dat", 64'(m_dat_i), 64'd0);
        chk("rst_status", 64'({err_valid, err_code}), 64'd0);
        chk("rst_err_adr", 64'(err_adr), 64'd0);
        tick(); rst = 1'b0;

        // Read slave0 with one wait state
        tick(); drive_req(1'b0, 32'h0010_0004, 32'h0, 4'hF);
        smp();  chk("rd_idle_stb", 64'(s_stb), 64'd0);
        tick(); smp();
        chk("rd_stb_t1", 64'(s_stb), 64'b01);
        chk("rd_cyc_t1", 64'(s_cyc), 64'b01);
        chk("rd_noack_t1", 64'(m_ack), 64'd0);
        tick(); s_dat[31:0] = 32'hDEAD_BEEF; s_ack = 2'b01;
        exp_q.push_back('{is_err: 1'b0, dat: 32'hDEAD_BEEF});
        smp();
        chk("rd_stb_t2", 64'(s_stb), 64'b01);
        chk("rd_ack_t2", 64'(m_ack), 64'd1);
        tick(); drop_req();
        smp();  chk("rd_done_stb", 64'(s_stb), 64'd0);

        // Write slave1; stray slave0 ACK ignored
        tick(); drive_req(1'b1, 32'h0100_0008, 32'h0000_0055, 4'b0001);
        smp();
        chk("wr_shared_dat", 64'(s_dat_i), 64'h55);
        chk("wr_shared_sel", 64'(s_sel), 64'b0001);
        chk("wr_shared_we", 64'(s_we), 64'd1);
        chk("wr_shared_adr", 64'(s_adr), 64'h0100_0008);
        tick(); s_ack = 2'b01; s_dat[31:0] = 32'h1111_1111;
        smp();
        chk("wr_stb_t1", 64'(s_stb), 64'b10);
        chk("wr_stray_ack", 64'(m_ack), 64'd0);
        tick(); s_ack = 2'b10; s_dat[63:32] = 32'h0000_00A5;
        exp_q.push_back('{is_err: 1'b0, dat: 32'h0000_00A5});
        smp();
        chk("wr_ack_t2", 64'(m_ack), 64'd1);
        tick(); drop_req();

        // Unmapped access
        tick(); drive_req(1'b0, 32'h2000_0000, 32'h0, 4'hF);
        exp_q.push_back('{is_err: 1'b1, dat: 32'h0});
        smp();  chk("miss_err_t0", 64'(m_err), 64'd0);
        tick(); smp();
        chk("miss_err_t1", 64'(m_err), 64'd1);
        chk("miss_no_stb", 64'({s_cyc, s_stb}), 64'd0);
        chk("miss_valid", 64'(err_valid), 64'd1);
        chk("miss_code", 64'(err_code), 64'b01);
        chk("miss_adr", 64'(err_adr), 64'h2000_0000);
        tick(); drop_req();
        smp();  chk("miss_err_t2", 64'(m_err), 64'd0);

        // Second miss must not overwrite the captured address
        tick(); drive_req(1'b0, 32'h3000_0000, 32'h0, 4'hF);
        exp_q.push_back('{is_err: 1'b1, dat: 32'h0});
        tick(); smp();
        chk("miss2_err", 64'(m_err), 64'd1);
        chk("miss2_adr_sticky", 64'(err_adr), 64'h2000_0000);
        tick(); drop_req();

        // Clear status
        tick(); err_clr = 1'b1;
        tick(); err_clr = 1'b0;
        smp();
        chk("clr_valid", 64'(err_valid), 64'd0);
        chk("clr_code", 64'(err_code), 64'd0);
        chk("clr_adr", 64'(err_adr), 64'd0);

        // Watchdog: slave0 never answers
        tick(); drive_req(1'b0, 32'h0010_0000, 32'h0, 4'hF);
        exp_q.push_back('{is_err: 1'b1, dat: 32'h0});
        for (int k = 1; k <= 4; k++) begin
            tick(); smp();
            chk($sformatf("to_stb_%0d", k), 64'(s_stb), 64'b01);
        end
        tick(); smp();
        chk("to_stb_dropped", 64'({s_cyc, s_stb}), 64'd0);
        chk("to_no_err_yet", 64'(m_err), 64'd0);
        tick(); smp();
        chk("to_err", 64'(m_err), 64'd1);
        chk("to_code", 64'(err_code), 64'b10);
        chk("to_adr", 64'(err_adr), 64'h0010_0000);
        tick(); drop_req();
        smp();  chk("to_err_one_cycle", 64'(m_err), 64'd0);

        // Abort in BUSY, then a normal zero-wait access
        tick(); drive_req(1'b0, 32'h0100_0000, 32'h0, 4'hF);
        tick(); smp();
        chk("ab_stb", 64'(s_stb), 64'b10);
        tick(); drop_req();
        smp();
        chk("ab_strobes_drop", 64'({s_cyc, s_stb}), 64'd0);
        chk("ab_no_term", 64'({m_ack, m_err}), 64'd0);
        tick(); drive_req(1'b0, 32'h0010_0008, 32'h0, 4'hF);
        tick(); s_ack = 2'b01; s_dat[31:0] = 32'hCAFE_F00D;
        exp_q.push_back('{is_err: 1'b0, dat: 32'hCAFE_F00D});
        smp();
        chk("ab_next_stb", 64'(s_stb), 64'b01);
        chk("ab_next_ack", 64'(m_ack), 64'd1);
        tick(); drop_req();

        // Asynchronous reset mid-BUSY
        tick(); drive_req(1'b0, 32'h0010_0010, 32'h0, 4'hF);
        tick(); smp();
        chk("rb_cyc_before", 64'(s_cyc), 64'b01);
        #2 rst = 1'b1;
        #1;
        chk("rb_cyc_async", 64'(s_cyc), 64'd0);
        chk("rb_status_lost", 64'({err_valid, err_code}), 64'd0);
        tick(); drop_req();
        tick(); rst = 1'b0;
        tick(); drive_req(1'b0, 32'h0010_0010, 32'h0, 4'hF);
        smp();  chk("rb_idle_stb", 64'(s_stb), 64'd0);
        tick(); s_ack = 2'b01; s_dat[31:0] = 32'h0BAD_F00D;
        exp_q.push_back('{is_err: 1'b0, dat: 32'h0BAD_F00D});
        smp();  chk("rb_first_ack", 64'(m_ack), 64'd1);
        tick(); drop_req();

        repeat (3) tick();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_interconnect_n.md
# wb_interconnect_n

Parametrised 1-master / N-slave Wishbone classic (standard-mode) interconnect for the dtcore32 data bus, with a registered per-transaction address decode. Sits between the core's data-side Wishbone master and its peripherals (dmem, uart, future slaves). Adds three protections:
- Slave select is locked for each transaction.
- Unmapped addresses are answered with a bus error instead of hanging.
- Stalled slaves trip a watchdog timeout that also returns an error.

Faulting address and cause are captured in sticky status registers.

## Interface
- WISHBONE_ADDR_WIDTH, 32, address width
- WISHBONE_BUS_WIDTH, 32, data width (multiple of 8)
- NUM_SLAVES, 2, number of slave ports (1..16)
- SLAVE_BASE, {32'h0100_0000, 32'h0010_0000}, packed NUM_SLAVES*ADDR_WIDTH, base of slave i at [i*AW +: AW]
- SLAVE_MASK, {32'hFFFF_0000, 32'hFFFF_0000}, packed; slave i hit when (ADR & MASK_i) == BASE_i
- TIMEOUT_CYCLES, 255, max cycles a granted transaction waits for ACK/ERR (>=1)
- CLK_I  in  1  clock; all state on rising edge
- RST_I  in  1  reset, asynchronous, active-high
- WBM_CYC_O, WBM_STB_O, WBM_WE_O  in  1 each  master strobes
- WBM_ADR_O  in  AW  master address
- WBM_DAT_O  in  BW  master write data
- WBM_SEL_O  in  BW/8  byte selects
- WBM_DAT_I  out  BW  read data to master
- WBM_ACK_I, WBM_ERR_I  out  1 each  termination to master
- WBS_ADR_I, WBS_WE_I, WBS_DAT_I, WBS_SEL_I  out  AW/1/BW/BW/8  shared to all slaves, direct copies of master
- WBS_CYC_I, WBS_STB_I  out  NUM_SLAVES  per-slave strobes
- WBS_DAT_O  in  NUM_SLAVES*BW  packed slave read data
- WBS_ACK_O, WBS_ERR_O  in  NUM_SLAVES  per-slave terminations
- ERR_VALID_O  out  1  sticky: an error was captured
- ERR_CODE_O  out  2  2'b01 unmapped, 2'b10 timeout
- ERR_ADR_O  out  AW  address of first captured error
- ERR_CLR_I  in  1  synchronous clear of the ERR_* status

## Operation
- FSM states: IDLE, BUSY, ERROR. Registers: state, sel_idx, timeout counter (clog2(TIMEOUT_CYCLES+1) bits), ERR_* status.
- IDLE, when CYC&STB is sampled:
  - Decode: lowest-index matching slave wins.
  - Hit: latch sel_idx, go to BUSY.
  - Miss: go to ERROR.
- IDLE outputs: all WBS_CYC_I/STB_I=0, WBM_ACK_I/ERR_I=0, WBM_DAT_I=0.
- BUSY routing:
  - WBS_CYC_I[sel_idx]=WBM_CYC_O and WBS_STB_I[sel_idx]=WBM_STB_O; all other slaves 0.
  - WBM_DAT_I, ACK_I, ERR_I come combinationally from slave sel_idx.
  - sel_idx is held; address changes during BUSY do not reroute.
- BUSY exits:
  - Selected ACK or ERR: forwarded this cycle, next state IDLE, counter cleared.
  - Master drops CYC (abort): next state IDLE, counter cleared, nothing forwarded.
  - Watchdog: counter increments each BUSY cycle without ACK/ERR. When it equals TIMEOUT_CYCLES, slave CYC/STB are forced to 0 that cycle, no termination is forwarded, and the next state is ERROR (cause = timeout).
- ERROR:
  - WBM_ERR_I=1 for exactly one cycle, WBM_ACK_I=0, WBM_DAT_I=0, no slave strobed. Next state IDLE unconditionally.
  - On entry, if ERR_VALID_O==0: ERR_VALID_O=1, ERR_CODE_O=cause, ERR_ADR_O=the address sampled in IDLE (miss) or latched at grant (timeout). Later errors do not overwrite.
- ERR_CLR_I clears ERR_VALID_O, ERR_CODE_O and ERR_ADR_O to 0. If a capture happens in the same cycle, the capture wins.
- A slave ACK/ERR arriving while not BUSY, or from a non-selected slave, is ignored.

## Timing
- Reset values: state IDLE; sel_idx 0; counter 0; ERR_VALID_O 0; ERR_CODE_O 0; ERR_ADR_O 0; all WBS_CYC_I/STB_I 0; WBM_ACK_I/ERR_I 0; WBM_DAT_I 0.
- Request latency: master asserts CYC/STB in cycle t, slave sees them in t+1. A slave ACK in cycle k reaches the master in the same cycle k.
- Best-case single access: 2 cycles (decode + zero-wait ACK).
- Back-to-back: after ACK in cycle k, FSM is IDLE at k+1; a new STB at k+1 is decoded then and granted at k+2.
- Unmapped access: request at t, WBM_ERR_I high at t+1 only.
- Timeout: grant at t+1, WBM_ERR_I high at t+1+TIMEOUT_CYCLES+1, one cycle.
- Reset mid-transaction: all outputs return to reset values immediately (asynchronous); status is lost.

## Test plan
- Read to 0x0010_0004, slave0 ACKs one cycle after its STB with DAT 0xDEADBEEF -> WBS_STB_I=2'b01 from t+1, WBM_ACK_I and WBM_DAT_I=0xDEADBEEF in the same cycle as slave ACK, slave1 never strobed.
- Write 0x0100_0008, data 0x55, SEL 4'b0001, slave1 ACK -> WBS_STB_I=2'b10, shared WBS_DAT_I=0x55, WBS_SEL_I=4'b0001; a slave0 ACK injected meanwhile is ignored.
- Access 0x2000_0000 -> WBM_ERR_I high exactly at t+1, no slave strobed, ERR_VALID_O=1, ERR_CODE_O=2'b01, ERR_ADR_O=0x2000_0000. A second miss at 0x3000_0000 leaves ERR_ADR_O unchanged; ERR_CLR_I clears all three status outputs to 0.
- TIMEOUT_CYCLES=4, slave0 never ACKs -> slave0 strobed 4 cycles, then dropped, WBM_ERR_I pulse one cycle later, ERR_CODE_O=2'b10.
- Abort: master drops CYC in BUSY before ACK -> slave strobes drop the same cycle, no ACK/ERR to master; the next request decodes normally.
- RST_I asserted mid-BUSY (asynchronous, off-edge) -> WBS_CYC_I=0 immediately, state IDLE; the first request after release takes 2 cycles.
